// File: rtl/player_controller.sv
// player_controller
//   One instance drives one on-screen character. Keyboard codes and collision
//   flags are turned into position and a movement state (Idle/Run/Jump/Fall
//   with gravity). Animation frames are sequenced per state. A mirrored
//   sprite-ROM address and a pixel-hit flag are produced for the VGA path.
//
// Ports
//   Clk, Reset          system clock, asynchronous active-high reset
//   frame_clk           vsync-rate strobe, edge-detected into a 1-Clk tick
//   revive              synchronous respawn (beats a coincident tick)
//   keycode_a/b         two USB key slots
//   on_ground           solid pixel directly under the feet
//   blocked_left/right  wall contact at the sprite edges
//   DrawX, DrawY        pixel currently being drawn
//   pos_x, pos_y        sprite top-left corner
//   anim_type           0 Idle, 1 Run, 2 Jump, 3 Fall
//   frame_index         animation frame within anim_type
//   facing_left         sprite mirrored horizontally
//   is_player           registered hit flag for DrawX/DrawY
//   sprite_addr         registered ROM address within one frame
module player_controller #(
   parameter int         WIDTH       = 32,
   parameter int         HEIGHT      = 48,
   parameter int         X_MIN       = 0,
   parameter int         X_MAX       = 639,
   parameter int         Y_MIN       = 0,
   parameter int         Y_MAX       = 479,
   parameter int         START_X     = 32,
   parameter int         START_Y     = 416,
   parameter int         VX          = 2,
   parameter int         JUMP_V      = 8,
   parameter int         GRAVITY     = 1,
   parameter int         VY_MAX      = 8,
   parameter logic [7:0] KEY_LEFT    = 8'h04,
   parameter logic [7:0] KEY_RIGHT   = 8'h07,
   parameter logic [7:0] KEY_JUMP    = 8'h1A,
   parameter int         IDLE_FRAMES = 4,
   parameter int         RUN_FRAMES  = 4,
   parameter int         FRAME_HOLD  = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        revive,
   input  logic [7:0]  keycode_a,
   input  logic [7:0]  keycode_b,
   input  logic        on_ground,
   input  logic        blocked_left,
   input  logic        blocked_right,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [9:0]  pos_x,
   output logic [9:0]  pos_y,
   output logic [1:0]  anim_type,
   output logic [2:0]  frame_index,
   output logic        facing_left,
   output logic        is_player,
   output logic [10:0] sprite_addr
);

   localparam logic signed [11:0] XLO       = 12'(X_MIN);
   localparam logic signed [11:0] XHI       = 12'(X_MAX - WIDTH + 1);
   localparam logic signed [11:0] YLO       = 12'(Y_MIN);
   localparam logic signed [11:0] YHI       = 12'(Y_MAX - HEIGHT + 1);
   localparam logic signed [9:0]  VX_S      = 10'(VX);
   localparam logic signed [9:0]  JUMP_S    = 10'(JUMP_V);
   localparam logic signed [9:0]  GRAV_S    = 10'(GRAVITY);
   localparam logic signed [9:0]  VYMAX_S   = 10'(VY_MAX);
   localparam logic [3:0]         HOLD_LAST = 4'(FRAME_HOLD - 1);
   localparam logic [9:0]         SX        = 10'(START_X);
   localparam logic [9:0]         SY        = 10'(START_Y);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_JUMP = 2'd2, S_FALL = 2'd3} state_t;

   logic               r_fclk, r_tick;
   logic [9:0]         r_x, r_y;
   logic signed [9:0]  r_vy;
   state_t             r_state;
   logic [2:0]         r_frame;
   logic [3:0]         r_hold;
   logic               r_face;
   logic               r_hit;
   logic [10:0]        r_addr;

   logic               w_left, w_right, w_jump, w_ground;
   logic signed [9:0]  w_vx, w_vy_g, w_vy_n;
   logic               w_face;
   logic signed [11:0] w_x_sum, w_y_sum;
   logic [9:0]         w_x_n, w_y_n;
   state_t             w_mv, w_state_n;
   logic [2:0]         w_last, w_frame_n;
   logic [3:0]         w_hold_n;
   logic [9:0]         w_offx, w_offy, w_col;
   logic               w_hit;
   logic [10:0]        w_addr;

   // Tick generator: one Clk pulse per rising edge of frame_clk.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_fclk <= 1'b0;
         r_tick <= 1'b0;
      end else begin
         r_fclk <= frame_clk;
         r_tick <= frame_clk & ~r_fclk;
      end
   end

   // Horizontal intent and X update
   always_comb begin
      w_left  = (keycode_a == KEY_LEFT)  || (keycode_b == KEY_LEFT);
      w_right = (keycode_a == KEY_RIGHT) || (keycode_b == KEY_RIGHT);
      w_jump  = (keycode_a == KEY_JUMP)  || (keycode_b == KEY_JUMP);
      w_vx    = '0;
      w_face  = r_face;
      if (w_left && w_right) begin
         w_vx = '0;
      end else if (w_left) begin
         // facing follows the key even when the wall stops the motion
         w_face = 1'b1;
         w_vx   = blocked_left ? 10'sd0 : -VX_S;
      end else if (w_right) begin
         w_face = 1'b0;
         w_vx   = blocked_right ? 10'sd0 : VX_S;
      end
      w_x_sum = {2'b00, r_x} + {{2{w_vx[9]}}, w_vx};
      if (w_x_sum < XLO)      w_x_n = XLO[9:0];
      else if (w_x_sum > XHI) w_x_n = XHI[9:0];
      else                    w_x_n = w_x_sum[9:0];
   end

   // Movement FSM and Y update; resting on the floor clamp counts as ground
   always_comb begin
      w_ground  = on_ground || ({2'b00, r_y} == YHI);
      w_mv      = (w_vx != 10'sd0) ? S_RUN : S_IDLE;
      w_vy_g    = r_vy + GRAV_S;
      w_state_n = r_state;
      w_vy_n    = r_vy;
      unique case (r_state)
         S_IDLE, S_RUN: begin
            if (w_jump && w_ground) begin
               w_state_n = S_JUMP;
               w_vy_n    = -JUMP_S;
            end else if (!w_ground) begin
               w_state_n = S_FALL;
               w_vy_n    = '0;
            end else begin
               w_state_n = w_mv;
               w_vy_n    = '0;
            end
         end
         S_JUMP: begin
            // apex reached once gravity cancels the upward speed
            if (!w_vy_g[9]) begin
               w_state_n = S_FALL;
               w_vy_n    = '0;
            end else begin
               w_vy_n = w_vy_g;
            end
         end
         S_FALL: begin
            if (w_ground) begin
               w_state_n = w_mv;
               w_vy_n    = '0;
            end else begin
               w_vy_n = (w_vy_g > VYMAX_S) ? VYMAX_S : w_vy_g;
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_vy_n    = '0;
         end
      endcase
      w_y_sum = {2'b00, r_y} + {{2{w_vy_n[9]}}, w_vy_n};
      if (w_y_sum < YLO) begin
         w_y_n = YLO[9:0];
         if (w_state_n == S_JUMP) begin
            w_state_n = S_FALL;
            w_vy_n    = '0;
         end
      end else if (w_y_sum > YHI) begin
         // landing is handled on the next tick via the floor-as-ground rule
         w_y_n = YHI[9:0];
      end else begin
         w_y_n = w_y_sum[9:0];
      end
   end

   // Animation sequencing
   always_comb begin
      unique case (w_state_n)
         S_IDLE:  w_last = 3'(IDLE_FRAMES - 1);
         S_RUN:   w_last = 3'(RUN_FRAMES - 1);
         default: w_last = 3'd0;
      endcase
      w_frame_n = r_frame;
      w_hold_n  = r_hold + 4'd1;
      if (w_state_n != r_state) begin
         w_frame_n = '0;
         w_hold_n  = '0;
      end else if (r_hold == HOLD_LAST) begin
         w_hold_n  = '0;
         w_frame_n = (r_frame == w_last) ? 3'd0 : r_frame + 3'd1;
      end
   end

   // Draw path: offsets wrap when left/above the sprite, so one unsigned
   // compare covers both sides.
   always_comb begin
      w_offx = DrawX - r_x;
      w_offy = DrawY - r_y;
      w_hit  = (w_offx < 10'(WIDTH)) && (w_offy < 10'(HEIGHT));
      w_col  = r_face ? (10'(WIDTH - 1) - w_offx) : w_offx;
      w_addr = w_hit ? (11'(w_offy) * 11'(WIDTH) + 11'(w_col)) : 11'd0;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_x     <= SX;
         r_y     <= SY;
         r_vy    <= '0;
         r_state <= S_IDLE;
         r_frame <= '0;
         r_hold  <= '0;
         r_face  <= 1'b0;
         r_hit   <= 1'b0;
         r_addr  <= '0;
      end else if (revive) begin
         r_x     <= SX;
         r_y     <= SY;
         r_vy    <= '0;
         r_state <= S_IDLE;
         r_frame <= '0;
         r_hold  <= '0;
         r_face  <= 1'b0;
         r_hit   <= 1'b0;
         r_addr  <= '0;
      end else begin
         r_hit  <= w_hit;
         r_addr <= w_addr;
         if (r_tick) begin
            r_x     <= w_x_n;
            r_y     <= w_y_n;
            r_vy    <= w_vy_n;
            r_state <= w_state_n;
            r_frame <= w_frame_n;
            r_hold  <= w_hold_n;
            r_face  <= w_face;
         end
      end
   end

   assign pos_x       = r_x;
   assign pos_y       = r_y;
   assign anim_type   = r_state;
   assign frame_index = r_frame;
   assign facing_left = r_face;
   assign is_player   = r_hit;
   assign sprite_addr = r_addr;

endmodule

// File: tb/tb_player_controller.sv
// Scoreboard bench for player_controller: stimulus pushes the hand-computed
// expected outputs and raises obs; the monitor pops and compares on negedge.
module tb_player_controller;

   logic        Clk = 1'b0;
   logic        Reset, frame_clk, revive;
   logic [7:0]  keycode_a, keycode_b;
   logic        on_ground, blocked_left, blocked_right;
   logic [9:0]  DrawX, DrawY;
   logic [9:0]  pos_x, pos_y;
   logic [1:0]  anim_type;
   logic [2:0]  frame_index;
   logic        facing_left, is_player;
   logic [10:0] sprite_addr;

   player_controller dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .revive(revive),
      .keycode_a(keycode_a), .keycode_b(keycode_b), .on_ground(on_ground),
      .blocked_left(blocked_left), .blocked_right(blocked_right),
      .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y),
      .anim_type(anim_type), .frame_index(frame_index), .facing_left(facing_left),
      .is_player(is_player), .sprite_addr(sprite_addr)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [9:0]  x, y;
      logic [1:0]  anim;
      logic [2:0]  fr;
      logic        face, hit;
      logic [10:0] addr;
      string       name;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   n_chk = 0;
   int   n_fail = 0;
   logic obs = 1'b0;

   always @(negedge Clk) begin
      if (obs) begin
         n_chk++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: output presented with no expectation");
         end else begin
            m_e = q.pop_front();
            if ({pos_x, pos_y, anim_type, frame_index, facing_left, is_player, sprite_addr} !==
                {m_e.x, m_e.y, m_e.anim, m_e.fr, m_e.face, m_e.hit, m_e.addr}) begin
               n_fail++;
               $display("FAIL %s: got x=%0d y=%0d anim=%0d fr=%0d face=%0d hit=%0d addr=%0d, want x=%0d y=%0d anim=%0d fr=%0d face=%0d hit=%0d addr=%0d",
                        m_e.name, pos_x, pos_y, anim_type, frame_index, facing_left, is_player, sprite_addr,
                        m_e.x, m_e.y, m_e.anim, m_e.fr, m_e.face, m_e.hit, m_e.addr);
            end
         end
      end
   end

   task automatic expect_now(input int x, input int y, input int anim, input int fr,
                             input int face, input int hit, input int addr, input string nm);
      exp_t e;
      e.x = 10'(x); e.y = 10'(y); e.anim = 2'(anim); e.fr = 3'(fr);
      e.face = 1'(face); e.hit = 1'(hit); e.addr = 11'(addr); e.name = nm;
      q.push_back(e);
      obs = 1'b1;
      @(negedge Clk);
      #1 obs = 1'b0;
   endtask

   task automatic tick();
      @(posedge Clk); #1 frame_clk = 1'b1;
      @(posedge Clk); #1 frame_clk = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic tchk(input int x, input int y, input int anim, input int fr,
                       input int face, input string nm);
      tick();
      expect_now(x, y, anim, fr, face, 0, 0, nm);
   endtask

   task automatic draw_chk(input int dx, input int dy, input int x, input int y, input int anim,
                           input int fr, input int face, input int hit, input int addr, input string nm);
      @(posedge Clk); #1 DrawX = 10'(dx); DrawY = 10'(dy);
      @(posedge Clk); #1;
      expect_now(x, y, anim, fr, face, hit, addr, nm);
      DrawX = 10'd1023; DrawY = 10'd1023;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int jy[8];
      int fy[7];
      jy = '{408, 401, 395, 390, 386, 383, 381, 380};
      fy = '{416, 417, 419, 422, 426, 431, 432};
      Reset = 1'b1; frame_clk = 1'b0; revive = 1'b0;
      keycode_a = '0; keycode_b = '0; on_ground = 1'b1;
      blocked_left = 1'b0; blocked_right = 1'b0;
      DrawX = 10'd1023; DrawY = 10'd1023;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      expect_now(32, 416, 0, 0, 0, 0, 0, "reset_state");

      // idle animation: advance every 4 ticks, wrap after 4 frames
      for (int k = 1; k <= 16; k++) tchk(32, 416, 0, (k / 4) % 4, 0, "idle_anim");

      // run left into the screen edge
      keycode_a = 8'h04;
      for (int k = 1; k <= 20; k++)
         tchk((32 - 2 * k < 0) ? 0 : 32 - 2 * k, 416, 1, ((k - 1) / 4) % 4, 1, "run_left");
      draw_chk(0, 416, 0, 416, 1, 0, 1, 1, 31, "draw_mirror_row0");
      draw_chk(31, 417, 0, 416, 1, 0, 1, 1, 32, "draw_mirror_row1");
      draw_chk(40, 416, 0, 416, 1, 0, 1, 0, 0, "draw_miss");
      keycode_a = 8'h00;
      tchk(0, 416, 0, 0, 1, "stop_idle");

      // jump arc then fall then land
      keycode_b = 8'h1A;
      for (int i = 0; i < 8; i++) tchk(0, jy[i], 2, 0, 1, "jump_arc");
      tchk(0, 380, 3, 0, 1, "jump_apex_fall");
      keycode_b = 8'h00;
      tchk(0, 380, 0, 0, 1, "fall_land");

      // respawn in the air, fall to floor clamp, land
      on_ground = 1'b0;
      @(posedge Clk); #1 revive = 1'b1;
      @(posedge Clk); #1 revive = 1'b0;
      expect_now(32, 416, 0, 0, 0, 0, 0, "revive");
      for (int i = 0; i < 7; i++) tchk(32, fy[i], 3, 0, 0, "fall_seq");
      tchk(32, 432, 0, 0, 0, "floor_land");
      tchk(32, 432, 0, 0, 0, "floor_rest");

      // conflicting keys and blocked wall
      on_ground = 1'b1;
      keycode_a = 8'h04;
      tchk(30, 432, 1, 0, 1, "left_step");
      keycode_a = 8'h07; keycode_b = 8'h04;
      tchk(30, 432, 0, 0, 1, "both_keys");
      keycode_b = 8'h00; blocked_right = 1'b1;
      tchk(30, 432, 0, 0, 0, "right_blocked");

      // revive colliding with a tick mid-jump
      keycode_a = 8'h00; blocked_right = 1'b0; keycode_b = 8'h1A;
      tchk(30, 424, 2, 0, 0, "jump2_a");
      tchk(30, 417, 2, 0, 0, "jump2_b");
      @(posedge Clk); #1 frame_clk = 1'b1;
      @(posedge Clk); #1 frame_clk = 1'b0; revive = 1'b1;
      @(posedge Clk); #1 revive = 1'b0; keycode_b = 8'h00;
      expect_now(32, 416, 0, 0, 0, 0, 0, "revive_on_tick");
      tchk(32, 416, 0, 0, 0, "after_revive");

      // async reset mid-jump while the sprite is being drawn
      keycode_b = 8'h1A;
      tchk(32, 408, 2, 0, 0, "jump3_a");
      tchk(32, 401, 2, 0, 0, "jump3_b");
      @(posedge Clk); #1 DrawX = 10'd32; DrawY = 10'd402;
      @(posedge Clk); #1;
      expect_now(32, 401, 2, 0, 0, 1, 32, "draw_jump");
      @(posedge Clk); #2 Reset = 1'b1;
      #1 expect_now(32, 416, 0, 0, 0, 0, 0, "async_reset");
      Reset = 1'b0;
      keycode_b = 8'h00;

      if (q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_leftover: %0d expectations unconsumed, want 0", q.size());
      end
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/player_controller.md
Name: player_controller

Overview:
Parametrised per-player controller for Fireboy/Icegirl-style characters. One instance drives each character.
- Turns keyboard codes and collision flags into position, velocity and a movement state machine: Idle, Run, Jump and Fall with gravity.
- Sequences animation frames per state.
- Produces a mirrored sprite-ROM read address and a pixel-hit flag for the VGA drawing path.
- Sits between the USB keycode interface / collision map and the sprite ROM and colour mapper.

Parameters:
WIDTH, 32, sprite width in pixels
HEIGHT, 48, sprite height in pixels
X_MIN, 0, leftmost legal X
X_MAX, 639, rightmost screen column
Y_MIN, 0, topmost legal Y
Y_MAX, 479, bottom screen row
START_X, 32, spawn X
START_Y, 416, spawn Y
VX, 2, horizontal speed in px/frame
JUMP_V, 8, initial upward speed in px/frame
GRAVITY, 1, vy increment per frame
VY_MAX, 8, terminal fall speed
KEY_LEFT, 8'h04, left keycode
KEY_RIGHT, 8'h07, right keycode
KEY_JUMP, 8'h1A, jump keycode
IDLE_FRAMES, 4, idle animation length (1-8)
RUN_FRAMES, 4, run animation length (1-8)
FRAME_HOLD, 4, frame ticks per animation step (1-16)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  VGA vsync-rate frame strobe (asynchronous to logic; edge-detected)
revive  in  1  synchronous respawn
keycode_a  in  8  key slot 0
keycode_b  in  8  key slot 1
on_ground  in  1  solid pixel directly under feet
blocked_left  in  1  wall at left edge
blocked_right  in  1  wall at right edge
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
pos_x  out  10  sprite top-left X
pos_y  out  10  sprite top-left Y
anim_type  out  2  0 Idle, 1 Run, 2 Jump, 3 Fall
frame_index  out  3  animation frame within anim_type
facing_left  out  1  1 = sprite mirrored
is_player  out  1  registered pixel-hit flag
sprite_addr  out  11  registered ROM address within one frame

Behaviour:
Reset and revive
- Reset (async) or revive (sync, highest priority) loads: pos = START; vx = vy = 0; state Idle; frame_index 0; hold counter 0; facing_left 0; is_player 0; sprite_addr 0.
- revive coinciding with a tick: revive wins; the tick is discarded.

Frame tick
- tick = registered rising edge of frame_clk: one Clk pulse, 1-Clk latency.
- All motion and animation updates occur only on tick.

Keys
- A key is pressed if keycode_a or keycode_b equals its code.
- Left and right both pressed: vx = 0, facing unchanged.
- Otherwise left gives vx = -VX, or 0 if blocked_left; right gives vx = +VX, or 0 if blocked_right.
- facing_left is set by left and cleared by right, even when blocked.

Arithmetic
- vx, vy are signed 10-bit.
- Position sums are computed in signed 12 bits, then clamped.
- X is clamped to [X_MIN, X_MAX-WIDTH+1]; Y is clamped to [Y_MIN, Y_MAX-HEIGHT+1].
- Y reaching the floor clamp counts as on_ground.

State machine (evaluated per tick; y_next = y + vy_next)
- Idle/Run: jump pressed and on_ground -> Jump, vy = -JUMP_V. Else !on_ground -> Fall, vy = 0. Else vx != 0 -> Run, else Idle.
- Jump: vy_next = vy + GRAVITY. If vy_next >= 0 -> Fall, vy = 0. Top clamp hit -> Fall, vy = 0. on_ground is ignored.
- Fall: if on_ground at tick -> land: vy = 0, y unchanged, Run if vx != 0 else Idle. Else vy_next = min(vy + GRAVITY, VY_MAX). Floor clamp hit -> land next tick.

Animation
- Hold counter increments every tick.
- When the counter reaches FRAME_HOLD-1, it clears and frame_index advances modulo the state's length. Idle uses IDLE_FRAMES, Run uses RUN_FRAMES, Jump and Fall use 1.
- Any state change clears frame_index and the hold counter on that tick.

Draw path
- offx = DrawX - pos_x, offy = DrawY - pos_y, unsigned.
- Hit when offx < WIDTH and offy < HEIGHT.
- Column = WIDTH-1-offx when facing_left, else offx.
- sprite_addr = offy*WIDTH + column, or 0 when not hit. Registered: 1-Clk latency from DrawX/DrawY.

Test Plan:
1. Reset with on_ground=1, no keys -> pos (32,416), Idle. frame_index cycles 0,1,2,3,0, advancing every 4 ticks.
2. keycode_a=04 held for 20 ticks with on_ground=1 -> x reaches 0 after 16 ticks and clamps at 0. Run state; facing_left=1. Pixel (0,416) gives sprite_addr 31; pixel (31,417) gives sprite_addr 32.
3. keycode_b=1A with on_ground=1 -> y sequence 408,401,395,390,386,383,381,380. The next tick enters Fall with y=380. Jump and Fall each hold frame_index 0.
4. Spawn with on_ground=0 -> y sequence 417,419,422,426,431, then 432 (floor clamp). The next tick lands in Idle with vy=0.
5. keycode_a=07, keycode_b=04 simultaneously -> vx=0 and facing unchanged. Then right with blocked_right=1 -> x unchanged, facing_left=0.
6. Mid-jump, revive pulsed in the same cycle as a tick -> pos (32,416), Idle, frame_index 0. Then assert async Reset mid-jump -> outputs take reset values immediately, without waiting for a Clk edge.
